// File: rtl/fetch_sequencer.sv
// Program-fetch controller: owns pc, resolves decoder jumps, and wraps fetch in a
// run/halt/single-step debug FSM with one hardware breakpoint.
module fetch_sequencer #(
    parameter int unsigned PM_AW      = 8,
    parameter logic [7:0]  NOP_OPCODE = 8'hC8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             jmp,
    input  logic             jmp_nz,
    input  logic             zero_flag,
    input  logic [3:0]       ir_nibble,
    input  logic [7:0]       pm_data,
    input  logic             halt_req,
    input  logic             resume_req,
    input  logic             step_req,
    input  logic             bp_en,
    input  logic [PM_AW-1:0] bp_addr,
    output logic [PM_AW-1:0] pm_addr,
    output logic [7:0]       next_instr,
    output logic             issue,
    output logic             halted,
    output logic [PM_AW-1:0] ir_pc,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_STEP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PM_AW-1:0] pc;
    logic             bp_skip;
    logic             taken;
    logic             bp_hit;
    logic             skip_set;

    assign taken  = jmp | (jmp_nz & ~zero_flag);
    assign bp_hit = bp_en & (pc == bp_addr) & ~bp_skip;

    // State register
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state <= S_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, issue decision and breakpoint-skip arming
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        skip_set  = 1'b0;
        unique case (state)
            S_RESET: begin
                state_nxt = halt_req ? S_HALT : S_RUN;
            end
            S_RUN: begin
                if (halt_req || bp_hit) begin
                    state_nxt = S_HALT;
                end else if (!taken) begin
                    issue = 1'b1;
                end
            end
            S_HALT: begin
                if (resume_req) begin
                    state_nxt = S_RUN;
                    skip_set  = 1'b1;
                end else if (step_req) begin
                    state_nxt = S_STEP;
                    skip_set  = 1'b1;
                end
            end
            S_STEP: begin
                if (!taken) begin
                    issue     = 1'b1;
                    state_nxt = S_HALT;
                end
            end
            default: state_nxt = S_RESET;
        endcase
        if (sync_reset) begin
            issue = 1'b0;
        end
    end

    // Fetch datapath: jumps beat sequential advance, jumps land in any state
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pc          <= '0;
            ir_pc       <= '0;
            instr_count <= '0;
            bp_skip     <= 1'b0;
        end else begin
            if (taken) begin
                pc <= {ir_pc[PM_AW-1:4], ir_nibble};
            end else if (issue) begin
                pc <= pc + PM_AW'(1);
            end
            if (issue) begin
                ir_pc       <= pc;
                instr_count <= instr_count + CNT_W'(1);
            end
            if (skip_set) begin
                bp_skip <= 1'b1;
            end else if (issue) begin
                bp_skip <= 1'b0;
            end
        end
    end

    assign pm_addr    = pc;
    assign next_instr = issue ? pm_data : NOP_OPCODE;
    assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; program memory modelled as data = addr + 8'h10.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        sync_reset;
    logic        jmp;
    logic        jmp_nz;
    logic        zero_flag;
    logic [3:0]  ir_nibble;
    logic [7:0]  pm_data;
    logic        halt_req;
    logic        resume_req;
    logic        step_req;
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic [7:0]  pm_addr;
    logic [7:0]  next_instr;
    logic        issue;
    logic        halted;
    logic [7:0]  ir_pc;
    logic [15:0] instr_count;

    int total = 0;
    int bad   = 0;

    fetch_sequencer dut (
        .clk         (clk),
        .sync_reset  (sync_reset),
        .jmp         (jmp),
        .jmp_nz      (jmp_nz),
        .zero_flag   (zero_flag),
        .ir_nibble   (ir_nibble),
        .pm_data     (pm_data),
        .halt_req    (halt_req),
        .resume_req  (resume_req),
        .step_req    (step_req),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .pm_addr     (pm_addr),
        .next_instr  (next_instr),
        .issue       (issue),
        .halted      (halted),
        .ir_pc       (ir_pc),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    assign pm_data = pm_addr + 8'h10;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        sync_reset = 1'b1; jmp = 1'b0; jmp_nz = 1'b0; zero_flag = 1'b0;
        ir_nibble = 4'h0; halt_req = 1'b0; resume_req = 1'b0; step_req = 1'b0;
        bp_en = 1'b0; bp_addr = 8'h00;
        repeat (2) cyc();
        #1;
        chk("rst_issue", 32'(issue), 32'd0);
        chk("rst_nop", 32'(next_instr), 32'hC8);
        chk("rst_pc", 32'(pm_addr), 32'h00);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_cnt", 32'(instr_count), 32'd0);
        chk("rst_irpc", 32'(ir_pc), 32'h00);

        // straight line from 0
        sync_reset = 1'b0;
        #1;
        chk("release_no_issue", 32'(issue), 32'd0);
        cyc();
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("line_pc", 32'(pm_addr), 32'(i));
            chk("line_issue", 32'(issue), 32'd1);
            chk("line_word", 32'(next_instr), 32'(i + 16));
            cyc();
        end
        #1;
        chk("line_cnt6", 32'(instr_count), 32'd6);
        chk("line_irpc", 32'(ir_pc), 32'h05);

        // free-run until ir_pc = 0x23
        for (int i = 0; i < 40 && pm_addr != 8'h24; i++) cyc();
        #1;
        chk("reach_24", 32'(pm_addr), 32'h24);
        chk("reach_irpc23", 32'(ir_pc), 32'h23);

        // jmp with nibble 9: squash 0x24, land on 0x29
        jmp = 1'b1; ir_nibble = 4'h9;
        #1;
        chk("jmp_squash_issue", 32'(issue), 32'd0);
        chk("jmp_squash_word", 32'(next_instr), 32'hC8);
        cyc();
        jmp = 1'b0;
        #1;
        chk("jmp_target", 32'(pm_addr), 32'h29);
        chk("jmp_irpc_hold", 32'(ir_pc), 32'h23);
        chk("jmp_target_issue", 32'(issue), 32'd1);
        cyc();
        #1;
        chk("jmp_irpc29", 32'(ir_pc), 32'h29);
        chk("jmp_pc2a", 32'(pm_addr), 32'h2A);

        // jmp_nz not taken (zero set) then taken
        jmp_nz = 1'b1; zero_flag = 1'b1; ir_nibble = 4'h3;
        #1;
        chk("jnz_nt_issue", 32'(issue), 32'd1);
        chk("jnz_nt_word", 32'(next_instr), 32'h3A);
        cyc();
        zero_flag = 1'b0;
        #1;
        chk("jnz_nt_seq", 32'(pm_addr), 32'h2B);
        chk("jnz_t_issue", 32'(issue), 32'd0);
        chk("jnz_t_word", 32'(next_instr), 32'hC8);
        cyc();
        jmp_nz = 1'b0;
        #1;
        chk("jnz_t_target", 32'(pm_addr), 32'h23);
        chk("jnz_cnt", 32'(instr_count), 32'd38);

        // breakpoint at 0x04
        sync_reset = 1'b1; bp_en = 1'b1; bp_addr = 8'h04;
        cyc();
        sync_reset = 1'b0;
        cyc();
        repeat (4) cyc();
        #1;
        chk("bp_pc4", 32'(pm_addr), 32'h04);
        chk("bp_no_issue", 32'(issue), 32'd0);
        cyc();
        #1;
        chk("bp_halted", 32'(halted), 32'd1);
        chk("bp_halt_pc", 32'(pm_addr), 32'h04);
        chk("bp_cnt4", 32'(instr_count), 32'd4);
        step_req = 1'b1;
        cyc();
        step_req = 1'b0;
        #1;
        chk("step_run", 32'(halted), 32'd0);
        chk("step_issue", 32'(issue), 32'd1);
        chk("step_word", 32'(next_instr), 32'h14);
        cyc();
        #1;
        chk("step_rehalt", 32'(halted), 32'd1);
        chk("step_pc5", 32'(pm_addr), 32'h05);
        chk("step_irpc4", 32'(ir_pc), 32'h04);
        chk("step_cnt5", 32'(instr_count), 32'd5);
        resume_req = 1'b1;
        cyc();
        resume_req = 1'b0;
        #1;
        chk("resume_run", 32'(halted), 32'd0);
        chk("resume_issue", 32'(issue), 32'd1);
        chk("resume_pc5", 32'(pm_addr), 32'h05);
        cyc();
        #1;
        chk("resume_pc6", 32'(pm_addr), 32'h06);
        chk("resume_issue6", 32'(issue), 32'd1);

        // halt, then step+resume together -> RUN
        halt_req = 1'b1;
        #1;
        chk("hreq_block", 32'(issue), 32'd0);
        cyc();
        halt_req = 1'b0;
        #1;
        chk("hreq_halted", 32'(halted), 32'd1);
        chk("hreq_pc6", 32'(pm_addr), 32'h06);
        step_req = 1'b1; resume_req = 1'b1;
        cyc();
        step_req = 1'b0; resume_req = 1'b0;
        #1;
        chk("both_issue", 32'(issue), 32'd1);
        cyc();
        #1;
        chk("both_still_run", 32'(halted), 32'd0);
        chk("both_issue2", 32'(issue), 32'd1);
        chk("both_pc7", 32'(pm_addr), 32'h07);

        // pc wrap FE -> FF -> 00
        bp_en = 1'b0;
        for (int i = 0; i < 300 && pm_addr != 8'hFE; i++) cyc();
        #1;
        chk("wrap_fe", 32'(pm_addr), 32'hFE);
        cyc();
        #1;
        chk("wrap_ff", 32'(pm_addr), 32'hFF);
        cyc();
        #1;
        chk("wrap_00", 32'(pm_addr), 32'h00);

        // reset during STEP with a jump pending
        halt_req = 1'b1;
        cyc();
        halt_req = 1'b0;
        step_req = 1'b1;
        cyc();
        step_req = 1'b0; jmp = 1'b1; ir_nibble = 4'h7;
        #1;
        chk("stepj_block", 32'(issue), 32'd0);
        chk("stepj_not_halted", 32'(halted), 32'd0);
        cyc();
        #1;
        chk("stepj_stay", 32'(halted), 32'd0);
        chk("stepj_target", 32'(pm_addr), 32'hF7);
        sync_reset = 1'b1;
        #1;
        chk("srst_issue", 32'(issue), 32'd0);
        chk("srst_word", 32'(next_instr), 32'hC8);
        cyc();
        jmp = 1'b0;
        #1;
        chk("srst_pc", 32'(pm_addr), 32'h00);
        chk("srst_cnt", 32'(instr_count), 32'd0);
        chk("srst_halted", 32'(halted), 32'd0);
        chk("srst_irpc", 32'(ir_pc), 32'h00);

        // RESET -> HALT when halt_req held; halt_req ignored while halted
        halt_req = 1'b1; sync_reset = 1'b0;
        cyc();
        #1;
        chk("rst2halt", 32'(halted), 32'd1);
        chk("rst2halt_issue", 32'(issue), 32'd0);
        cyc();
        #1;
        chk("halt_hold", 32'(halted), 32'd1);
        halt_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-fetch controller for the 8-bit core. Owns the program counter, drives the program-memory address, and resolves jmp/jmp_nz from the instruction decoder.
- Feeds next_instr into the decoder's ir register.
- Adds a debug run/halt/single-step state machine with one hardware breakpoint. When the core is not issuing, it injects the NOP opcode 8'hC8.

Parameters:
- PM_AW, 8, program-memory address width (pc width).
- NOP_OPCODE, 8'hC8, opcode injected on non-issue cycles.
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- sync_reset  input  1  synchronous, active-high reset.
- jmp  input  1  decoder: unconditional jump in ir.
- jmp_nz  input  1  decoder: conditional jump in ir.
- zero_flag  input  1  ALU zero flag; conditional jump taken when 0.
- ir_nibble  input  4  decoder: ir[3:0], jump target low nibble.
- pm_data  input  8  program-memory read data for pm_addr (combinational read).
- halt_req  input  1  debug: request halt (level).
- resume_req  input  1  debug: leave HALT, free-run.
- step_req  input  1  debug: execute exactly one instruction.
- bp_en  input  1  breakpoint enable.
- bp_addr  input  PM_AW  breakpoint address.
- pm_addr  output  PM_AW  program-memory address (= pc register).
- next_instr  output  8  word to decoder ir.
- issue  output  1  next_instr carries a real fetched word this cycle.
- halted  output  1  state == HALT.
- ir_pc  output  PM_AW  address of the word currently in ir.
- instr_count  output  CNT_W  issued-instruction count.

Behaviour:
- States: RESET, RUN, HALT, STEP.
- sync_reset forces the following on the next edge, overriding all other inputs, including mid-step or mid-jump:
  - state=RESET, pc=0, ir_pc=0, instr_count=0, bp_skip=0.
  - While sync_reset is high, issue=0 and next_instr=NOP_OPCODE.
  - halted=0 in RESET.
- taken = jmp | (jmp_nz & ~zero_flag). This is evaluated every cycle regardless of state.
- bp_hit = bp_en & (pc == bp_addr) & ~bp_skip.
- issue is 1 in exactly these cases:
  - state==RUN & ~taken & ~bp_hit & ~halt_req.
  - state==STEP & ~taken.
- next_instr = issue ? pm_data : NOP_OPCODE. This is combinational, so the fall-through word after a taken jump is squashed (no delay slot).
- pc next-value priority:
  1. reset: 0.
  2. taken: {ir_pc[7:4], ir_nibble}.
  3. issue: pc+1, wrapping 8'hFF to 8'h00.
  4. otherwise: hold.
- ir_pc <= pc when issue; otherwise hold.
- instr_count increments by 1 on each issue cycle and wraps at 2^CNT_W.
- bp_skip:
  - Set on HALT->RUN and on HALT->STEP.
  - Cleared on the first issue cycle after being set.
  - Its purpose is to let resume leave a breakpoint address.
- Transitions:
  - RESET -> HALT if halt_req, else -> RUN. Both take one cycle after sync_reset deasserts. No issue occurs in RESET.
  - RUN -> HALT when halt_req or bp_hit. No word issues that cycle; the breakpointed instruction is not executed.
  - HALT -> RUN on resume_req.
  - HALT -> STEP on step_req.
  - resume_req and step_req together: resume wins.
  - halt_req is ignored in HALT.
  - STEP -> HALT after the cycle with issue=1. STEP remains while taken blocks issue.
  - bp_hit and halt_req are ignored in STEP.
- A taken jump still in ir when entering HALT updates pc. Jumps are never lost.
- The breakpoint compares pc (the fetch address), not ir_pc.

Test Plan:
- Reset then run a straight-line program at 0x00..0x05. Required response:
  - pm_addr 00,01,02,...
  - issue=1 from the 2nd cycle after reset release.
  - instr_count=6 after six issues.
- jmp in ir at ir_pc=0x23 with ir_nibble=4'h9. Required response:
  - The word at 0x24 is squashed (next_instr=8'hC8).
  - Next pm_addr=0x29.
  - ir_pc becomes 0x29 one cycle later.
- jmp_nz with zero_flag=0 gives target {hi,nibble}. The same instruction with zero_flag=1 gives pc+1 sequential with no squash.
- bp_en=1, bp_addr=0x04, RUN from 0. Required response:
  - halted=1 with pm_addr=0x04 and 0x04 not issued.
  - step_req issues 0x04 only, then HALT at pm_addr=0x05.
  - resume_req continues to 0x05, 0x06, ...
- In HALT, assert step_req and resume_req in the same cycle -> state RUN. Also run pc from 0xFE: 0xFE -> 0xFF -> 0x00 wrap.
- Assert sync_reset during STEP while a jump is in ir -> pc=0, instr_count=0, next_instr=8'hC8, halted=0.
